// File: rtl/rst_seq_pkg.sv
// Shared constants for the reset sequencer: state encoding, default parameters, widths.
package rst_seq_pkg;

    localparam int STATE_W      = 2;
    localparam int IDX_W        = 3;
    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_STEP_CYC = 16;
    localparam int DEF_WDT_CYC  = 500;
    localparam int DEF_CNT_W    = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

endpackage

// File: rtl/rst_seq_wdt.sv
// Watchdog for the reset sequencer: counts RUN cycles, cleared by kick, pulses at terminal count.
module rst_seq_wdt import rst_seq_pkg::*; #(
    parameter int WDT_CYC = DEF_WDT_CYC,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic kick,
    output logic tmo
);

    logic [CNT_W-1:0] cnt;
    logic             term;

    assign term = (cnt == CNT_W'(WDT_CYC - 1));
    assign tmo  = en & term & ~kick;

    // Held at zero outside RUN so the count always starts fresh on entry.
    always_ff @(posedge clk) begin
        if (rst || clr || !en || kick || term) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Staged per-channel reset release with soft-reset request and optional watchdog.
// Watchdog is built only when RST_SEQ_WDT_EN is defined.
module rst_sequencer import rst_seq_pkg::*; #(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int STEP_CYC = DEF_STEP_CYC,
    parameter int WDT_CYC  = DEF_WDT_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               hclk_i,
    input  logic               hrst_i,
    input  logic               ext_rst_req_i,
    input  logic               kick_i,
    output logic [NUM_CH-1:0]  rst_n_o,
    output logic               all_rel_o,
    output logic               wdt_timeout_o,
    output logic [STATE_W-1:0] state_o
);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [NUM_CH-1:0]  rel, rel_nx;
    logic               armed;
    logic               step_done;
    logic               tmo;

    assign step_done = (cnt == CNT_W'(STEP_CYC - 1));

`ifdef RST_SEQ_WDT_EN
    logic wdt_flag;

    rst_seq_wdt #(
        .WDT_CYC (WDT_CYC),
        .CNT_W   (CNT_W)
    ) u_wdt (
        .clk  (hclk_i),
        .rst  (hrst_i),
        .clr  (ext_rst_req_i),
        .en   (state == ST_RUN),
        .kick (kick_i),
        .tmo  (tmo)
    );

    always_ff @(posedge hclk_i) begin
        if (hrst_i) begin
            wdt_flag <= 1'b0;
        end else if (tmo && !ext_rst_req_i) begin
            wdt_flag <= 1'b1;
        end
    end

    assign wdt_timeout_o = wdt_flag;
`else
    logic unused_kick;
    localparam int unused_wdt_cyc = WDT_CYC;

    assign unused_kick   = kick_i;
    assign tmo           = 1'b0;
    assign wdt_timeout_o = 1'b0;
`endif

    // armed stays low for the first edge after hrst so release timing counts from that edge.
    always_ff @(posedge hclk_i) begin
        if (hrst_i) begin
            state <= ST_ASSERT;
            cnt   <= '0;
            idx   <= '0;
            rel   <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            rel   <= rel_nx;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        rel_nx   = rel;
        if (ext_rst_req_i || tmo) begin
            state_nx = ST_ASSERT;
            cnt_nx   = '0;
            idx_nx   = '0;
            rel_nx   = '0;
        end else begin
            case (state)
                ST_ASSERT, ST_RELEASE: begin
                    if (armed) begin
                        if (step_done) begin
                            cnt_nx = '0;
                            rel_nx = rel | (NUM_CH'(1) << idx);
                            if (idx == IDX_W'(NUM_CH - 1)) begin
                                state_nx = ST_RUN;
                                idx_nx   = '0;
                            end else begin
                                state_nx = ST_RELEASE;
                                idx_nx   = idx + IDX_W'(1);
                            end
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    state_nx = ST_RUN;
                end
                default: begin
                    state_nx = ST_ASSERT;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    rel_nx   = '0;
                end
            endcase
        end
    end

    assign rst_n_o   = rel;
    assign all_rel_o = (state == ST_RUN);
    assign state_o   = state;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: default instance plus a NUM_CH=1/STEP_CYC=1 instance.
module tb_rst_sequencer;

    logic       hclk_i = 1'b0;
    logic       hrst_i;
    logic       ext_rst_req_i;
    logic       kick_i;
    logic [3:0] rst_n;
    logic       all_rel;
    logic       wdt_to;
    logic [1:0] state;
    logic [0:0] s_rst_n;
    logic       s_all_rel;
    logic       s_wdt_to;
    logic [1:0] s_state;

    int tests = 0;
    int fails = 0;

    rst_sequencer dut (
        .hclk_i        (hclk_i),
        .hrst_i        (hrst_i),
        .ext_rst_req_i (ext_rst_req_i),
        .kick_i        (kick_i),
        .rst_n_o       (rst_n),
        .all_rel_o     (all_rel),
        .wdt_timeout_o (wdt_to),
        .state_o       (state)
    );

    rst_sequencer #(
        .NUM_CH   (1),
        .STEP_CYC (1)
    ) dut_small (
        .hclk_i        (hclk_i),
        .hrst_i        (hrst_i),
        .ext_rst_req_i (ext_rst_req_i),
        .kick_i        (kick_i),
        .rst_n_o       (s_rst_n),
        .all_rel_o     (s_all_rel),
        .wdt_timeout_o (s_wdt_to),
        .state_o       (s_state)
    );

    always #5 hclk_i = ~hclk_i;

    task automatic applyStimulus(input logic rst, input logic ext, input logic kick);
        hrst_i        = rst;
        ext_rst_req_i = ext;
        kick_i        = kick;
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge hclk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    initial begin
        // Power-on reset and release order from cycle 0
        applyStimulus(1'b1, 1'b0, 1'b0);
        ticks(2);
        checkOutput("rst_rst_n", 32'(rst_n), 32'h0);
        checkOutput("rst_all_rel", 32'(all_rel), 32'h0);
        checkOutput("rst_wdt_to", 32'(wdt_to), 32'h0);
        checkOutput("rst_state", 32'(state), 32'h0);
        checkOutput("small_rst_rst_n", 32'(s_rst_n), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        ticks(1);
        checkOutput("small_c0_rst_n", 32'(s_rst_n), 32'h0);
        checkOutput("small_c0_state", 32'(s_state), 32'h0);
        ticks(1);
        checkOutput("small_c1_rst_n", 32'(s_rst_n), 32'h1);
        checkOutput("small_c1_state", 32'(s_state), 32'h2);
        checkOutput("small_c1_all_rel", 32'(s_all_rel), 32'h1);
        ticks(14);
        checkOutput("c15_rst_n", 32'(rst_n), 32'h0);
        checkOutput("c15_state", 32'(state), 32'h0);
        ticks(1);
        checkOutput("c16_rst_n", 32'(rst_n), 32'h1);
        checkOutput("c16_state", 32'(state), 32'h1);
        ticks(15);
        checkOutput("c31_rst_n", 32'(rst_n), 32'h1);
        ticks(1);
        checkOutput("c32_rst_n", 32'(rst_n), 32'h3);
        ticks(16);
        checkOutput("c48_rst_n", 32'(rst_n), 32'h7);
        ticks(15);
        checkOutput("c63_rst_n", 32'(rst_n), 32'h7);
        checkOutput("c63_all_rel", 32'(all_rel), 32'h0);
        ticks(1);
        checkOutput("c64_rst_n", 32'(rst_n), 32'hF);
        checkOutput("c64_all_rel", 32'(all_rel), 32'h1);
        checkOutput("c64_state", 32'(state), 32'h2);

        // Soft reset pulse sampled at cycle 41
        applyStimulus(1'b1, 1'b0, 1'b0);
        ticks(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        ticks(41);
        checkOutput("ext_c40_rst_n", 32'(rst_n), 32'h3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        ticks(1);
        checkOutput("ext_c41_rst_n", 32'(rst_n), 32'h0);
        checkOutput("ext_c41_all_rel", 32'(all_rel), 32'h0);
        checkOutput("ext_c41_state", 32'(state), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        ticks(15);
        checkOutput("ext_c56_rst_n", 32'(rst_n), 32'h0);
        ticks(1);
        checkOutput("ext_c57_rst_n", 32'(rst_n), 32'h1);
        ticks(48);
        checkOutput("ext_c105_rst_n", 32'(rst_n), 32'hF);
        checkOutput("ext_c105_state", 32'(state), 32'h2);

        // Soft reset held: stays in ASSERT, restarts on release
        applyStimulus(1'b0, 1'b1, 1'b0);
        ticks(5);
        checkOutput("hold_state", 32'(state), 32'h0);
        checkOutput("hold_rst_n", 32'(rst_n), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        ticks(15);
        checkOutput("hold_p15_rst_n", 32'(rst_n), 32'h0);
        ticks(1);
        checkOutput("hold_p16_rst_n", 32'(rst_n), 32'h1);
        ticks(48);
        checkOutput("hold_p64_state", 32'(state), 32'h2);

`ifdef RST_SEQ_WDT_EN
        // Periodic kicks, then kick exactly at terminal count
        applyStimulus(1'b1, 1'b0, 1'b0);
        ticks(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        ticks(65);
        checkOutput("kick_run_state", 32'(state), 32'h2);
        for (int i = 0; i < 13; i++) begin
            ticks(399);
            applyStimulus(1'b0, 1'b0, 1'b1);
            ticks(1);
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("kick_loop_wdt_to", 32'(wdt_to), 32'h0);
            checkOutput("kick_loop_all_rel", 32'(all_rel), 32'h1);
        end
        ticks(499);
        checkOutput("term_pre_wdt_to", 32'(wdt_to), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        ticks(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("term_kick_wdt_to", 32'(wdt_to), 32'h0);
        checkOutput("term_kick_state", 32'(state), 32'h2);
        ticks(499);
        checkOutput("term_499_wdt_to", 32'(wdt_to), 32'h0);
        ticks(1);
        checkOutput("term_500_wdt_to", 32'(wdt_to), 32'h1);
        checkOutput("term_500_rst_n", 32'(rst_n), 32'h0);
        checkOutput("term_500_state", 32'(state), 32'h0);
        checkOutput("term_500_all_rel", 32'(all_rel), 32'h0);
        ticks(16);
        checkOutput("term_rerel_rst_n", 32'(rst_n), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        ticks(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ext_keep_rst_n", 32'(rst_n), 32'h0);
        checkOutput("ext_keep_wdt_to", 32'(wdt_to), 32'h1);

        // No kicks: timeout at cycle 564, re-release 580..628
        applyStimulus(1'b1, 1'b0, 1'b0);
        ticks(1);
        checkOutput("hrst_clr_wdt_to", 32'(wdt_to), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        ticks(65);
        ticks(499);
        checkOutput("c563_wdt_to", 32'(wdt_to), 32'h0);
        checkOutput("c563_rst_n", 32'(rst_n), 32'hF);
        ticks(1);
        checkOutput("c564_wdt_to", 32'(wdt_to), 32'h1);
        checkOutput("c564_rst_n", 32'(rst_n), 32'h0);
        checkOutput("c564_state", 32'(state), 32'h0);
        ticks(15);
        checkOutput("c579_rst_n", 32'(rst_n), 32'h0);
        ticks(1);
        checkOutput("c580_rst_n", 32'(rst_n), 32'h1);
        ticks(16);
        checkOutput("c596_rst_n", 32'(rst_n), 32'h3);
        ticks(16);
        checkOutput("c612_rst_n", 32'(rst_n), 32'h7);
        ticks(16);
        checkOutput("c628_rst_n", 32'(rst_n), 32'hF);
        checkOutput("c628_state", 32'(state), 32'h2);
        checkOutput("c628_wdt_to", 32'(wdt_to), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        ticks(1);
        checkOutput("run_hrst_wdt_to", 32'(wdt_to), 32'h0);
        checkOutput("run_hrst_state", 32'(state), 32'h0);
        checkOutput("run_hrst_rst_n", 32'(rst_n), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);
`else
        // Without the watchdog RUN holds indefinitely
        applyStimulus(1'b1, 1'b0, 1'b0);
        ticks(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        ticks(65);
        checkOutput("nowdt_run_state", 32'(state), 32'h2);
        for (int i = 0; i < 10; i++) begin
            ticks(1000);
            checkOutput("nowdt_wdt_to", 32'(wdt_to), 32'h0);
            checkOutput("nowdt_all_rel", 32'(all_rel), 32'h1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4, number of reset channels; legal range 1..8.
REQ-002 Parameter STEP_CYC, default 16, clock cycles between successive channel releases; minimum 1.
REQ-003 Parameter WDT_CYC, default 500, watchdog timeout in cycles; minimum 2.
REQ-004 Parameter CNT_W, default 16, width of the internal counters; STEP_CYC and WDT_CYC SHALL fit in CNT_W bits.
REQ-005 hclk_i  input  1  single clock; all logic is on its rising edge.
REQ-006 hrst_i  input  1  reset, synchronous and active-high.
REQ-007 ext_rst_req_i  input  1  soft reset request, level-sampled.
REQ-008 kick_i  input  1  watchdog kick, level-sampled.
REQ-009 rst_n_o  output  NUM_CH  per-channel active-low resets to downstream domains; bit k is channel k.
REQ-010 all_rel_o  output  1  high while every channel is released.
REQ-011 wdt_timeout_o  output  1  sticky watchdog-timeout flag.
REQ-012 state_o  output  2  current FSM state: ASSERT=0, RELEASE=1, RUN=2.

Function
REQ-013 The FSM SHALL have three states: ASSERT, RELEASE and RUN.
REQ-014 ASSERT SHALL hold all rst_n_o low, then move to RELEASE after STEP_CYC cycles.
REQ-015 In RELEASE, channel k SHALL go high at the edge exactly (k+1)*STEP_CYC cycles after the first edge that samples hrst_i=0; release order is ch0 first.
REQ-016 Once released, a channel SHALL stay high until a reassertion event (REQ-019, REQ-020, REQ-023).
REQ-017 On the edge that releases channel NUM_CH-1, all_rel_o SHALL go high and the FSM SHALL enter RUN.
REQ-018 In RUN, the watchdog counter SHALL clear on entry, increment each cycle, and clear on any cycle with kick_i=1.
REQ-019 In RUN, at counter==WDT_CYC-1 with kick_i=0: on the next edge, wdt_timeout_o=1 (sticky), all rst_n_o=0, all_rel_o=0, FSM=ASSERT, counters cleared.
REQ-020 ext_rst_req_i=1 in any state: on the next edge, all rst_n_o=0, all_rel_o=0, FSM=ASSERT, counters cleared; wdt_timeout_o unchanged.
REQ-021 Priority SHALL be hrst_i > ext_rst_req_i > timeout > kick_i.
REQ-022 Simultaneous kick_i and terminal count SHALL clear the counter with no timeout; kick_i outside RUN SHALL be ignored.
REQ-023 ext_rst_req_i held high SHALL keep the FSM in ASSERT; sequencing restarts from zero on the first edge it is sampled low.
REQ-024 Internal counters SHALL never wrap: the step counter resets at STEP_CYC-1 and the watchdog counter at its terminal count.

Reset
REQ-025 hrst_i=1 SHALL give rst_n_o=0, all_rel_o=0, wdt_timeout_o=0, state_o=ASSERT, all counters 0 at the next edge, including mid-sequence.
REQ-026 There SHALL be no asynchronous reset path.

Configuration
REQ-027 Macro RST_SEQ_WDT_EN defined: the watchdog behaves per REQ-018/019/022.
REQ-028 Macro RST_SEQ_WDT_EN undefined: the watchdog logic SHALL be absent, RUN is terminal except for hrst_i and ext_rst_req_i, kick_i is ignored, and wdt_timeout_o is tied 0.

Structure
REQ-029 Package rst_seq_pkg SHALL hold the state encoding constants, the default parameter values and the state_o width.
REQ-030 The watchdog SHALL be the sub-module rst_seq_wdt (counter, kick clear, terminal pulse), instantiated only under RST_SEQ_WDT_EN.
REQ-031 The top level SHALL contain the FSM, the step counter and the channel index.

Verification (defaults, RST_SEQ_WDT_EN defined, cycle 0 = first edge with hrst_i=0)
REQ-032 Release order: rst_n_o bits go high at cycles 16, 32, 48, 64; all_rel_o and state_o=RUN at cycle 64.
REQ-033 Watchdog: kick_i pulsed every 400 cycles -> no timeout for 5000 cycles; kicks stopped after entry to RUN -> wdt_timeout_o=1 and rst_n_o=0 at cycle 564, then re-release at 580/596/612/628.
REQ-034 Soft reset and priority:
- ext_rst_req_i pulsed at cycle 40 -> rst_n_o=0 at cycle 41, re-release starts 16 cycles later.
- hrst_i asserted in RUN after a timeout -> wdt_timeout_o cleared.
REQ-035 Boundary: kick_i at the terminal-count cycle -> no timeout; NUM_CH=1, STEP_CYC=1 -> release at cycle 1, RUN at cycle 1.
REQ-036 Macro undefined: no kicks for 10000 cycles -> wdt_timeout_o stays 0, all_rel_o stays 1.
